// File: rtl/imm_encoder_pkg.sv
// Shared types for the LA32R immediate encoder: instruction/data words, the
// immediate format enumeration, the per-format field mask and a range helper.
package imm_encoder_pkg;

   typedef logic [31:0] Instr;
   typedef logic [31:0] DType;

   typedef enum logic [2:0] {
      ITYPE_NONE = 3'd0,
      ITYPE_I8   = 3'd1,
      ITYPE_I12  = 3'd2,
      ITYPE_I14  = 3'd3,
      ITYPE_I16  = 3'd4,
      ITYPE_I20  = 3'd5,
      ITYPE_I21  = 3'd6,
      ITYPE_I26  = 3'd7
   } Itype;

   localparam int IMM_ERR_CNT_W_DEF = 16;

   // Instruction bits occupied by the immediate of each format.
   function automatic Instr imm_field_mask(Itype t);
      Instr m;
      case (t)
         ITYPE_I8:  m = 32'h0000_7C00;
         ITYPE_I12: m = 32'h003F_FC00;
         ITYPE_I14: m = 32'h00FF_FC00;
         ITYPE_I16: m = 32'h03FF_FC00;
         ITYPE_I20: m = 32'h01FF_FFE0;
         ITYPE_I21: m = 32'h03FF_FC1F;
         ITYPE_I26: m = 32'h03FF_FFFF;
         default:   m = 32'h0000_0000;
      endcase
      return m;
   endfunction

   // True when v[31:b] are all copies of v[b], i.e. v fits a (b+1)-bit signed field.
   function automatic logic sext_ok(DType v, int unsigned b);
      logic signed [31:0] s;
      s = $signed(v) >>> b;
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/imm_encoder_pack_check.sv
// Combinational immediate packer: slices the immediate into the instruction
// field positions of the selected format and flags range/alignment errors.
// With IMM_ENCODER_SELFCHECK_EN defined this file also provides imm_gen, the
// decode-side immediate generator used to cross-check the encoder output.
module imm_pack_check
   import imm_encoder_pkg::*;
(
   input  Itype       itype_i,
   input  logic       unsign_i,
   input  DType       imm_i,
   output Instr       field_o,
   output Instr       mask_o,
   output logic       err_o
);

   // Field placement and error detection; field bits are the truncated slices
   // regardless of whether the immediate is representable.
   always_comb begin
      field_o = '0;
      mask_o  = imm_field_mask(itype_i);
      err_o   = 1'b0;
      case (itype_i)
         ITYPE_I8: begin
            field_o[14:10] = imm_i[4:0];
            err_o          = |imm_i[31:5];
         end
         ITYPE_I12: begin
            field_o[21:10] = imm_i[11:0];
            err_o          = unsign_i ? (|imm_i[31:12]) : !sext_ok(imm_i, 11);
         end
         ITYPE_I14: begin
            field_o[23:10] = imm_i[15:2];
            err_o          = (|imm_i[1:0]) || !sext_ok(imm_i, 15);
         end
         ITYPE_I16: begin
            field_o[25:10] = imm_i[17:2];
            err_o          = (|imm_i[1:0]) || !sext_ok(imm_i, 17);
         end
         ITYPE_I20: begin
            field_o[24:5]  = imm_i[31:12];
            err_o          = |imm_i[11:0];
         end
         ITYPE_I21: begin
            field_o[4:0]   = imm_i[20:16];
            field_o[25:10] = imm_i[15:0];
            err_o          = !sext_ok(imm_i, 20);
         end
         ITYPE_I26: begin
            field_o[9:0]   = imm_i[27:18];
            field_o[25:10] = imm_i[17:2];
            err_o          = (|imm_i[1:0]) || !sext_ok(imm_i, 27);
         end
         default: begin
            field_o = '0;
            err_o   = 1'b0;
         end
      endcase
   end

endmodule

`ifdef IMM_ENCODER_SELFCHECK_EN
// Decode-side immediate generator: recovers the immediate from an encoded word.
module imm_gen
   import imm_encoder_pkg::*;
(
   input  Instr  instr_i,
   input  Itype  itype_i,
   input  logic  unsign_i,
   output DType  imm_o,
   output logic  valid_o
);

   // Reassemble and extend the immediate according to its format.
   always_comb begin
      imm_o   = '0;
      valid_o = 1'b1;
      case (itype_i)
         ITYPE_I8:  imm_o = {27'b0, instr_i[14:10]};
         ITYPE_I12: imm_o = unsign_i ? {20'b0, instr_i[21:10]}
                                     : {{20{instr_i[21]}}, instr_i[21:10]};
         ITYPE_I14: imm_o = {{16{instr_i[23]}}, instr_i[23:10], 2'b00};
         ITYPE_I16: imm_o = {{14{instr_i[25]}}, instr_i[25:10], 2'b00};
         ITYPE_I20: imm_o = {instr_i[24:5], 12'b0};
         ITYPE_I21: imm_o = {{11{instr_i[4]}}, instr_i[4:0], instr_i[25:10]};
         ITYPE_I26: imm_o = {{4{instr_i[9]}}, instr_i[9:0], instr_i[25:10], 2'b00};
         default:   valid_o = 1'b0;
      endcase
   end

endmodule
`endif

// File: rtl/imm_encoder.sv
// LA32R immediate encoder: merges an immediate into a base instruction behind
// a single-entry valid/ready output register and keeps a saturating count of
// erroneous requests.
// Optional macro IMM_ENCODER_SELFCHECK_EN adds a decode cross-check and the
// sticky selfcheck_fail output.
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int ERR_CNT_W = IMM_ERR_CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  Instr                 in_base,
   input  Itype                 in_itype,
   input  logic                 in_unsign,
   input  DType                 in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output Instr                 out_instr,
   output logic                 out_err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 clr_err
`ifdef IMM_ENCODER_SELFCHECK_EN
   ,output logic                selfcheck_fail
`endif
);

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   Instr                 pk_field;
   Instr                 pk_mask;
   logic                 pk_err;
   logic                 accept;

   logic                 out_valid_q, out_valid_d;
   Instr                 out_instr_q, out_instr_d;
   logic                 out_err_q,   out_err_d;
   logic                 sticky_q,    sticky_d;
   logic [ERR_CNT_W-1:0] cnt_q,       cnt_d;

   imm_pack_check u_pack (
      .itype_i  (in_itype),
      .unsign_i (in_unsign),
      .imm_i    (in_imm),
      .field_o  (pk_field),
      .mask_o   (pk_mask),
      .err_o    (pk_err)
   );

   // The register can take a new request whenever it is empty or being drained.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Next state of the output register and the error counters; clear beats increment.
   always_comb begin
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_err_d   = out_err_q;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_instr_d = (in_base & ~pk_mask) | pk_field;
         out_err_d   = pk_err;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (clr_err) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (accept && pk_err) begin
         sticky_d = 1'b1;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // State registers with synchronous active-low reset; a pending result is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_err_q   <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_err_q   <= out_err_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_instr  = out_instr_q;
   assign out_err    = out_err_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;

`ifdef IMM_ENCODER_SELFCHECK_EN
   Itype sc_itype_q;
   logic sc_unsign_q;
   DType sc_imm_q;
   DType sc_dec;
   logic sc_dec_vld;
   logic sc_bad;
   logic sc_fail_q;

   // Remember the request that produced the registered result.
   always_ff @(posedge clk) begin
      if (accept) begin
         sc_itype_q  <= in_itype;
         sc_unsign_q <= in_unsign;
         sc_imm_q    <= in_imm;
      end
   end

   imm_gen u_gen (
      .instr_i  (out_instr_q),
      .itype_i  (sc_itype_q),
      .unsign_i (sc_unsign_q),
      .imm_o    (sc_dec),
      .valid_o  (sc_dec_vld)
   );

   // An in-range result must decode back to exactly the requested immediate.
   assign sc_bad = out_valid_q && !out_err_q && sc_dec_vld && (sc_dec != sc_imm_q);

   // Sticky self-check failure flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sc_fail_q <= 1'b0;
      end else if (sc_bad) begin
         sc_fail_q <= 1'b1;
      end
   end

   assign selfcheck_fail = sc_fail_q;

   a_roundtrip: assert property (@(posedge clk) disable iff (!rst_n) !sc_bad);
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed vectors with literal expectations plus a
// cycle-level reference model compared against the DUT every cycle.
module tb_imm_encoder;
   import imm_encoder_pkg::*;

   localparam int CW = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [31:0]   in_base   = '0;
   Itype          in_itype  = ITYPE_NONE;
   logic          in_unsign = 1'b0;
   logic [31:0]   in_imm    = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_instr;
   logic          out_err;
   logic          err_sticky;
   logic [CW-1:0] err_cnt;
   logic          clr_err   = 1'b0;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic        m_valid  = 1'b0;
   logic [31:0] m_instr  = '0;
   logic        m_err    = 1'b0;
   logic        m_sticky = 1'b0;
   int          m_cnt    = 0;
   logic [31:0] dlv[$];

   Itype        tbl_t [8] = '{ITYPE_NONE, ITYPE_I8, ITYPE_I12, ITYPE_I14,
                              ITYPE_I16, ITYPE_I20, ITYPE_I21, ITYPE_I26};
   logic [31:0] tbl_x [8] = '{32'hFFFF_FFFF, 32'hFFFF_83FF, 32'hFFC0_03FF, 32'hFF00_03FF,
                              32'hFC00_03FF, 32'hFE00_001F, 32'hFC00_03E0, 32'hFC00_0000};

   always #5 clk = ~clk;

   imm_encoder #(.ERR_CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_base    (in_base),
      .in_itype   (in_itype),
      .in_unsign  (in_unsign),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_err    (out_err),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt),
      .clr_err    (clr_err)
   );

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endfunction

   // where the bits of value v land in the instruction for format t
   function automatic logic [31:0] place(Itype t, logic [31:0] v);
      case (t)
         ITYPE_I8:  return (v & 32'h1F) << 10;
         ITYPE_I12: return (v & 32'hFFF) << 10;
         ITYPE_I14: return ((v >> 2) & 32'h3FFF) << 10;
         ITYPE_I16: return ((v >> 2) & 32'hFFFF) << 10;
         ITYPE_I20: return (v >> 12) << 5;
         ITYPE_I21: return ((v >> 16) & 32'h1F) | ((v & 32'hFFFF) << 10);
         ITYPE_I26: return ((v >> 18) & 32'h3FF) | (((v >> 2) & 32'hFFFF) << 10);
         default:   return 32'h0;
      endcase
   endfunction

   function automatic void m_encode(input logic [31:0] b, input Itype t, input logic u,
                                    input logic [31:0] imm, output logic [31:0] o,
                                    output logic e);
      longint s;
      s = longint'($signed(imm));
      case (t)
         ITYPE_I8:  e = imm > 32'd31;
         ITYPE_I12: e = u ? (imm > 32'd4095) : (s < -2048 || s > 2047);
         ITYPE_I14: e = (imm % 4 != 0) || s < -32768 || s > 32767;
         ITYPE_I16: e = (imm % 4 != 0) || s < -131072 || s > 131071;
         ITYPE_I20: e = (imm % 4096) != 0;
         ITYPE_I21: e = s < -1048576 || s > 1048575;
         ITYPE_I26: e = (imm % 4 != 0) || s < -134217728 || s > 134217727;
         default:   e = 1'b0;
      endcase
      o = (b & ~place(t, 32'hFFFF_FFFF)) | place(t, imm);
   endfunction

   // reference model, advanced on every rising edge
   always @(posedge clk) begin : model
      logic        rdy, acc, e;
      logic [31:0] o;
      rdy = !m_valid || out_ready;
      if (!rst_n) begin
         m_valid = 1'b0; m_instr = '0; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 0;
      end else begin
         acc = in_valid && rdy;
         o = '0; e = 1'b0;
         if (acc) m_encode(in_base, in_itype, in_unsign, in_imm, o, e);
         if (acc) begin
            m_valid = 1'b1; m_instr = o; m_err = e;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         if (clr_err) begin
            m_sticky = 1'b0; m_cnt = 0;
         end else if (acc && e) begin
            m_sticky = 1'b1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
         end
      end
   end

   // compare DUT against model mid-cycle
   always @(negedge clk) begin
      chk("mdl_in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
      chk("mdl_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
         chk("mdl_out_instr", out_instr, m_instr);
         chk("mdl_out_err", {31'b0, out_err}, {31'b0, m_err});
      end
      chk("mdl_sticky", {31'b0, err_sticky}, {31'b0, m_sticky});
      chk("mdl_cnt", {{(32-CW){1'b0}}, err_cnt}, m_cnt);
      if (out_valid && out_ready) dlv.push_back(out_instr);
   end

   // one request with out_ready high; called and returns at posedge+1
   task automatic send(input logic [31:0] b, input Itype t, input logic u, input logic [31:0] imm,
                       input logic [31:0] exp_i, input logic exp_e, input string nm);
      in_base = b; in_itype = t; in_unsign = u; in_imm = imm;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({nm, "_instr"}, out_instr, exp_i);
      chk({nm, "_err"}, {31'b0, out_err}, {31'b0, exp_e});
   endtask

   initial begin
      int n;
      int cyc;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_err", {31'b0, out_err}, 32'd0);
      chk("rst_sticky", {31'b0, err_sticky}, 32'd0);
      chk("rst_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'd0);

      send(32'h0280_0000, ITYPE_I12, 1'b0, 32'hFFFF_FFFF, 32'h02BF_FC00, 1'b0, "i12_m1");
      send(32'h0280_0000, ITYPE_I12, 1'b0, 32'h0000_0800, 32'h02A0_0000, 1'b1, "i12_ovf");
      chk("i12_ovf_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'd1);
      chk("i12_ovf_sticky", {31'b0, err_sticky}, 32'd1);
      send(32'h0280_0000, ITYPE_I12, 1'b1, 32'h0000_0800, 32'h02A0_0000, 1'b0, "i12_uns");
      send(32'h0280_0000, ITYPE_I12, 1'b1, 32'h0000_1000, 32'h0280_0000, 1'b1, "i12_uns_ovf");
      send(32'h0280_0000, ITYPE_I12, 1'b0, 32'hFFFF_F800, 32'h02A0_0000, 1'b0, "i12_min");
      send(32'h5400_0000, ITYPE_I26, 1'b0, 32'hFFFF_FFFC, 32'h57FF_FFFF, 1'b0, "i26_m4");
      send(32'h5000_0000, ITYPE_I26, 1'b0, 32'h0000_1004, 32'h5010_0400, 1'b0, "i26_pos");
      send(32'h1400_0000, ITYPE_I20, 1'b0, 32'h1234_5000, 32'h1424_68A0, 1'b0, "i20_ok");
      send(32'h1400_0000, ITYPE_I20, 1'b0, 32'h1234_5001, 32'h1424_68A0, 1'b1, "i20_mis");
      send(32'h0000_0000, ITYPE_I8,  1'b0, 32'h0000_0005, 32'h0000_1400, 1'b0, "i8_ok");
      send(32'h0000_0000, ITYPE_I8,  1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1, "i8_ovf");
      send(32'h0000_0000, ITYPE_I14, 1'b0, 32'hFFFF_8000, 32'h0080_0000, 1'b0, "i14_min");
      send(32'h0000_0000, ITYPE_I14, 1'b0, 32'h0000_8000, 32'h0080_0000, 1'b1, "i14_ovf");
      send(32'h0000_0000, ITYPE_I14, 1'b0, 32'h0000_0006, 32'h0000_0400, 1'b1, "i14_mis");
      send(32'h0000_0000, ITYPE_I16, 1'b0, 32'h0001_FFFC, 32'h01FF_FC00, 1'b0, "i16_max");
      send(32'h0000_0000, ITYPE_I16, 1'b0, 32'h0002_0000, 32'h0200_0000, 1'b1, "i16_ovf");
      send(32'h0000_0000, ITYPE_I21, 1'b0, 32'hFFF0_0000, 32'h0000_0010, 1'b0, "i21_min");
      send(32'h0000_0000, ITYPE_I21, 1'b0, 32'h0010_0000, 32'h0000_0010, 1'b1, "i21_ovf");
      send(32'h1234_5678, ITYPE_NONE, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, "none");
      for (int i = 0; i < 8; i++) begin
         send(32'hFFFF_FFFF, tbl_t[i], 1'b0, 32'h0, tbl_x[i], 1'b0, $sformatf("clrbase%0d", i));
      end

      // backpressure: three back-to-back requests, consumer stalled 4 cycles
      repeat (2) @(posedge clk);
      #1 dlv.delete();
      in_base = '0; in_itype = ITYPE_I8; in_unsign = 1'b0; in_valid = 1'b1;
      n = 0; cyc = 0;
      while (n < 3 && cyc < 40) begin
         out_ready = (cyc >= 4);
         in_imm = n + 1;
         #1;
         if (cyc == 1) chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
         if (cyc == 3) chk("bp_hold", out_instr, 32'h0000_0400);
         if (in_ready) n++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      chk("bp_accepts", n, 32'd3);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_count", dlv.size(), 32'd3);
      if (dlv.size() == 3) begin
         chk("bp_ord0", dlv[0], 32'h0000_0400);
         chk("bp_ord1", dlv[1], 32'h0000_0800);
         chk("bp_ord2", dlv[2], 32'h0000_0C00);
      end

      // clear coinciding with an erroneous accept
      clr_err = 1'b1;
      send(32'h0, ITYPE_I8, 1'b0, 32'h20, 32'h0, 1'b1, "clr_same");
      clr_err = 1'b0;
      chk("clr_same_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'd0);
      chk("clr_same_sticky", {31'b0, err_sticky}, 32'd0);

      // saturation
      in_base = '0; in_itype = ITYPE_I8; in_imm = 32'h20; in_valid = 1'b1; out_ready = 1'b1;
      repeat ((1 << CW) + 3) @(posedge clk);
      #1 in_valid = 1'b0;
      chk("sat_cnt", {{(32-CW){1'b0}}, err_cnt}, (1 << CW) - 1);
      chk("sat_sticky", {31'b0, err_sticky}, 32'd1);
      clr_err = 1'b1;
      @(posedge clk); #1 clr_err = 1'b0;
      chk("clr_cnt", {{(32-CW){1'b0}}, err_cnt}, 32'd0);
      chk("clr_sticky", {31'b0, err_sticky}, 32'd0);

      // reset while a result is pending
      out_ready = 1'b0;
      in_itype = ITYPE_I8; in_imm = 32'h7; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      chk("rstmid_pending", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_valid", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("rstmid_noreplay", {31'b0, out_valid}, 32'd0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
